eth_tx_framer: RTL and testbench
================================

# eth_tx_framer

Transmit-side Ethernet framer sitting directly downstream of the TCP packet sender. It consumes complete frames as a byte stream, from destination MAC through the final FCS byte, and drives a GMII-style byte interface toward the PHY. It prepends preamble and SFD and enforces the inter-frame gap. Because the PHY side cannot be stalled, upstream underrun or an oversized frame aborts the frame with an error symbol.

## Interface
Parameters:
- DATA_WIDTH, `INPUTWIDTH: stream byte width; only 8 is supported.
- PREAMBLE_BYTES, 7: count of 0x55 symbols before the SFD.
- IFG_BYTES, 12: minimum number of tx_en-low cycles between frames; must be ≥2.
- MAX_FRAME_BYTES, 1522: maximum accepted bytes per frame, FCS included.

Ports:
- clk  in  1  single clock; one GMII byte per cycle.
- rst  in  1  asynchronous, active-high reset.
- s_axis  axi_stream_if.slave  tdata[DATA_WIDTH]/tvalid/tready/tlast  frame input; tlast marks the final FCS byte.
- gmii_txd  out  8  transmit byte.
- gmii_tx_en  out  1  frame-active qualifier.
- gmii_tx_er  out  1  error symbol qualifier.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  one-cycle pulse when a frame is aborted by underrun or oversize.

## Operation
- States: IDLE, PRE, SFD, DATA, TAIL, ERR, DRAIN, IFG.
- gmii_txd, gmii_tx_en and gmii_tx_er are registered outputs.
- s_axis.tready is combinational and equals (state ∈ {SFD, DATA, DRAIN}).
- IDLE, on s_axis.tvalid:
  - Next edge: txd=0x55, tx_en=1, state PRE.
  - No byte is consumed.
- PRE:
  - Holds 0x55 for PREAMBLE_BYTES cycles total.
  - Then txd=0xD5 and state SFD.
- SFD / DATA with tvalid=1:
  - The accepted byte appears on txd at the next edge, with tx_en=1.
  - A 16-bit byte counter increments.
  - If the accepted byte has tlast, state goes to TAIL; otherwise it goes to DATA.
- TAIL: tready=0. Next edge sets tx_en=0, txd=0x00 and state IFG.
- IFG:
  - Lasts IFG_BYTES-1 cycles, then IDLE.
  - The IDLE cycle supplies the final gap cycle, so back-to-back frames get exactly IFG_BYTES cycles of tx_en=0.
- Underrun (state SFD or DATA with tvalid=0):
  - Next edge: txd=0x00, tx_en=1, tx_er=1, state ERR, underrun pulses.
- Oversize:
  - Triggered by a byte accepted when the counter already equals MAX_FRAME_BYTES.
  - The byte is discarded.
  - Enters ERR exactly as for underrun.
  - If that byte carried tlast, ERR is followed by IFG and DRAIN is skipped.
- ERR: next edge sets tx_en=0 and tx_er=0. State goes to DRAIN, or to IFG if tlast has already been consumed.
- DRAIN: accepts and discards bytes until a tlast byte is accepted, then IFG. gmii outputs stay idle.
- The byte counter clears on entering PRE.

## Timing
- Reset values (applied asynchronously): gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, busy=0, underrun=0, s_axis.tready=0, state IDLE, counters 0.
- Frame start, with tvalid first seen in IDLE at cycle 0:
  - 0x55 on cycles 1..7.
  - 0xD5 on cycle 8.
  - byte0 accepted at the end of cycle 8 and shown on cycle 9.
- Data latency: each accepted byte is shown exactly one cycle after acceptance.
- Throughput: one byte per cycle during DATA. Any tvalid gap is fatal (underrun).
- Reset mid-frame: outputs drop immediately and the framer returns to IDLE. Upstream must be reset in the same cycle; the next tvalid after reset starts a new frame.
- Simultaneous tlast and oversize: oversize takes priority and the frame is aborted.

## Configuration
- TX_FRAMER_STATS_EN defined: adds outputs
  - frames_sent[31:0]: increments on each TAIL→IFG transition.
  - frames_aborted[15:0]: increments on each ERR entry.
  - Both are saturating and reset to 0.
- TX_FRAMER_STATS_EN undefined: neither port nor the counters exist; all other behaviour is identical.

## Test plan
- 64-byte frame (0x00..0x3F, tlast on 0x3F), tvalid continuous:
  - txd shows 7×0x55, 0xD5, then 0x00..0x3F on consecutive cycles.
  - tx_en high for exactly 72 cycles; tx_er never high.
- Two 64-byte frames offered back-to-back → tx_en low for exactly 12 cycles between them.
- tvalid dropped after byte 20 of 64:
  - Next cycle tx_er=1, tx_en=1, txd=0x00, underrun pulses.
  - Then tx_en=0.
  - Remaining bytes are consumed with no GMII activity; IFG follows tlast.
- 1600-byte frame with MAX_FRAME_BYTES=1522:
  - Bytes 0..1521 are transmitted.
  - Byte 1522 is discarded and ERR is signalled.
  - The rest is drained; frames_aborted=1 with stats enabled.
- rst asserted at the 10th data byte → same-cycle tx_en=0, busy=0; a following 64-byte frame transmits cleanly.
- Stats build, 3 good frames and 1 underrun → frames_sent=3, frames_aborted=1.

Source files
------------

// File: rtl/axi_stream_if.sv
// Byte-stream handshake bundle (tdata/tvalid/tready/tlast) between the TCP sender and the Ethernet TX framer.
`ifndef INPUTWIDTH
`define INPUTWIDTH 8
`endif

interface axi_stream_if #(
  parameter int DATA_WIDTH = `INPUTWIDTH
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: prepends preamble/SFD, enforces the inter-frame gap and aborts on underrun/oversize.
// Optional TX_FRAMER_STATS_EN adds saturating frames_sent / frames_aborted counters.
`ifndef INPUTWIDTH
`define INPUTWIDTH 8
`endif

module eth_tx_framer #(
  parameter int DATA_WIDTH      = `INPUTWIDTH,
  parameter int PREAMBLE_BYTES  = 7,
  parameter int IFG_BYTES       = 12,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic        clk,
  input  logic        rst,
  axi_stream_if.slave s_axis,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic        underrun
`ifdef TX_FRAMER_STATS_EN
  ,
  output logic [31:0] frames_sent,
  output logic [15:0] frames_aborted
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_SFD   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_TAIL  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;
  localparam logic [2:0] ST_DRAIN = 3'd6;
  localparam logic [2:0] ST_IFG   = 3'd7;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_BYTES);

  localparam logic [7:0] SYM_PRE = 8'h55;
  localparam logic [7:0] SYM_SFD = 8'hD5;

  logic [2:0]  state, state_nx;
  logic [7:0]  pre_cnt, pre_cnt_nx;
  logic [7:0]  ifg_cnt, ifg_cnt_nx;
  logic [15:0] byte_cnt, byte_cnt_nx;
  logic        tlast_seen, tlast_seen_nx;
  logic [7:0]  txd_nx;
  logic        tx_en_nx, tx_er_nx, underrun_nx;
  logic        frame_done, frame_abort;

  assign s_axis.tready = (state == ST_SFD) || (state == ST_DATA) || (state == ST_DRAIN);
  assign busy          = (state != ST_IDLE);

  // NOTE: every signal assigned here gets a default first so no path can infer a latch.
  always_comb begin
    state_nx      = state;
    pre_cnt_nx    = pre_cnt;
    ifg_cnt_nx    = ifg_cnt;
    byte_cnt_nx   = byte_cnt;
    tlast_seen_nx = tlast_seen;
    txd_nx        = 8'h00;
    tx_en_nx      = 1'b0;
    tx_er_nx      = 1'b0;
    underrun_nx   = 1'b0;
    frame_done    = 1'b0;
    frame_abort   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (s_axis.tvalid) begin
          state_nx    = ST_PRE;
          txd_nx      = SYM_PRE;
          tx_en_nx    = 1'b1;
          pre_cnt_nx  = 8'd1;
          byte_cnt_nx = 16'd0;
        end
      end

      ST_PRE: begin
        tx_en_nx = 1'b1;
        if (pre_cnt >= PRE_LAST) begin
          txd_nx   = SYM_SFD;
          state_nx = ST_SFD;
        end else begin
          txd_nx     = SYM_PRE;
          pre_cnt_nx = pre_cnt + 8'd1;
        end
      end

      ST_SFD, ST_DATA: begin
        // The PHY cannot stall, so a missing byte or one past the size limit kills the frame.
        if (!s_axis.tvalid || (byte_cnt == MAX_LEN)) begin
          state_nx      = ST_ERR;
          tx_en_nx      = 1'b1;
          tx_er_nx      = 1'b1;
          underrun_nx   = 1'b1;
          frame_abort   = 1'b1;
          tlast_seen_nx = s_axis.tvalid && s_axis.tlast;
        end else begin
          txd_nx      = s_axis.tdata[7:0];
          tx_en_nx    = 1'b1;
          byte_cnt_nx = byte_cnt + 16'd1;
          state_nx    = s_axis.tlast ? ST_TAIL : ST_DATA;
        end
      end

      ST_TAIL: begin
        state_nx   = ST_IFG;
        ifg_cnt_nx = 8'd1;
        frame_done = 1'b1;
      end

      ST_ERR: begin
        ifg_cnt_nx = 8'd1;
        state_nx   = tlast_seen ? ST_IFG : ST_DRAIN;
      end

      ST_DRAIN: begin
        if (s_axis.tvalid && s_axis.tlast) begin
          state_nx   = ST_IFG;
          ifg_cnt_nx = 8'd1;
        end
      end

      ST_IFG: begin
        // One gap cycle short: the IDLE cycle that sees the next tvalid supplies the last one.
        if (ifg_cnt >= IFG_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          ifg_cnt_nx = ifg_cnt + 8'd1;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pre_cnt    <= 8'd0;
      ifg_cnt    <= 8'd0;
      byte_cnt   <= 16'd0;
      tlast_seen <= 1'b0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      pre_cnt    <= pre_cnt_nx;
      ifg_cnt    <= ifg_cnt_nx;
      byte_cnt   <= byte_cnt_nx;
      tlast_seen <= tlast_seen_nx;
      gmii_txd   <= txd_nx;
      gmii_tx_en <= tx_en_nx;
      gmii_tx_er <= tx_er_nx;
      underrun   <= underrun_nx;
    end
  end

`ifdef TX_FRAMER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_sent    <= 32'd0;
      frames_aborted <= 16'd0;
    end else begin
      if (frame_done && (frames_sent != 32'hFFFF_FFFF)) begin
        frames_sent <= frames_sent + 32'd1;
      end
      if (frame_abort && (frames_aborted != 16'hFFFF)) begin
        frames_aborted <= frames_aborted + 16'd1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = frame_done ^ frame_abort;
`endif

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: expected GMII symbols are queued as stimulus is driven.
module tb_eth_tx_framer;

  localparam int MAXF = 1522;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_stream_if #(.DATA_WIDTH(8)) s_axis ();

  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, busy, underrun;
`ifdef TX_FRAMER_STATS_EN
  logic [31:0] frames_sent;
  logic [15:0] frames_aborted;
`endif

  eth_tx_framer dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis        (s_axis),
    .gmii_txd      (gmii_txd),
    .gmii_tx_en    (gmii_tx_en),
    .gmii_tx_er    (gmii_tx_er),
    .busy          (busy),
    .underrun      (underrun)
`ifdef TX_FRAMER_STATS_EN
    ,
    .frames_sent   (frames_sent),
    .frames_aborted(frames_aborted)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Expected symbols while tx_en is high: {tx_er, txd}.
  logic [8:0] exp_q[$];

  int hi_run = 0, lo_run = 0, last_hi = 0, last_gap = 0, und_cnt = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    logic [8:0] exp_sym;
    if (!rst) begin
      if (underrun) und_cnt++;
      if (gmii_tx_en) begin
        if (!prev_en) last_gap = lo_run;
        hi_run++;
        lo_run = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL gmii_sym: got er=%b txd=%h, expected no active symbol", gmii_tx_er, gmii_txd);
        end else begin
          exp_sym = exp_q.pop_front();
          if ({gmii_tx_er, gmii_txd} !== exp_sym) begin
            errors++;
            $display("FAIL gmii_sym: got er=%b txd=%h, expected er=%b txd=%h",
                     gmii_tx_er, gmii_txd, exp_sym[8], exp_sym[7:0]);
          end
        end
        if (gmii_tx_er) begin
          checks++;
          if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_with_er: got %b, expected 1", underrun);
          end
        end
      end else begin
        if (prev_en) last_hi = hi_run;
        hi_run = 0;
        lo_run++;
        checks++;
        if (gmii_tx_er !== 1'b0) begin
          errors++;
          $display("FAIL tx_er_idle: got %b, expected 0", gmii_tx_er);
        end
      end
      prev_en = gmii_tx_en;
    end
  end

  task automatic push_preamble();
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
  endtask

  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 8'(i)});
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, 8'h00});
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Presents one byte and returns just after the edge that accepted it.
  task automatic drive_byte(input logic [7:0] d, input logic last);
    bit ok = 0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tlast  = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (s_axis.tready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL handshake_timeout: byte %h never accepted", d);
    end
  endtask

  task automatic send_frame(input int len, input int drop_after);
    for (int i = 0; i < len; i++) begin
      drive_byte(8'(i), (i == len - 1));
      if (i == drop_after) begin
        s_axis.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    bit ok = 0;
    cycles = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (!busy) begin
        cycles = c;
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: busy still %b after 300 cycles, expected 0", busy);
    end
  endtask

  task automatic do_reset();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tdata  = 8'h00;
    rst = 1'b1;
    #1;
    expect_int("reset_txd", int'(gmii_txd), 0);
    expect_int("reset_tx_en", int'(gmii_tx_en), 0);
    expect_int("reset_tx_er", int'(gmii_tx_er), 0);
    expect_int("reset_busy", int'(busy), 0);
    expect_int("reset_underrun", int'(underrun), 0);
    expect_int("reset_tready", int'(s_axis.tready), 0);
`ifdef TX_FRAMER_STATS_EN
    expect_int("reset_frames_sent", int'(frames_sent), 0);
    expect_int("reset_frames_aborted", int'(frames_aborted), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int cyc;
    int und0 = und_cnt;
    push_preamble();
    push_bytes(64);
    send_frame(64, -1);
    wait_idle(cyc);
    expect_int("single_tx_en_len", last_hi, 72);
    expect_int("single_no_underrun", und_cnt, und0);
    expect_int("single_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int f = 0; f < 2; f++) begin
      push_preamble();
      push_bytes(64);
    end
    send_frame(64, -1);
    send_frame(64, -1);
    wait_idle(cyc);
    expect_int("b2b_gap", last_gap, 12);
    expect_int("b2b_tx_en_len", last_hi, 72);
    expect_int("b2b_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_underrun();
    int cyc;
    int und0 = und_cnt;
`ifdef TX_FRAMER_STATS_EN
    int ab0 = int'(frames_aborted);
`endif
    push_preamble();
    push_bytes(21);
    push_err();
    send_frame(64, 20);
    wait_idle(cyc);
    expect_int("underrun_pulses", und_cnt, und0 + 1);
    expect_int("underrun_tx_en_len", last_hi, 30);
    expect_int("underrun_queue_empty", exp_q.size(), 0);
`ifdef TX_FRAMER_STATS_EN
    expect_int("underrun_frames_aborted", int'(frames_aborted), ab0 + 1);
`endif
  endtask

  task automatic test_oversize();
    int cyc;
    int und0 = und_cnt;
`ifdef TX_FRAMER_STATS_EN
    int ab0 = int'(frames_aborted);
`endif
    push_preamble();
    push_bytes(MAXF);
    push_err();
    send_frame(1600, -1);
    wait_idle(cyc);
    expect_int("oversize_pulses", und_cnt, und0 + 1);
    expect_int("oversize_tx_en_len", last_hi, 8 + MAXF + 1);
    expect_int("oversize_queue_empty", exp_q.size(), 0);
`ifdef TX_FRAMER_STATS_EN
    expect_int("oversize_frames_aborted", int'(frames_aborted), ab0 + 1);
`endif
  endtask

  // tlast on the first over-limit byte: ERR goes straight to IFG (1 + 11 cycles, idle on the 13th).
  task automatic test_oversize_tlast();
    int cyc;
    int und0 = und_cnt;
    push_preamble();
    push_bytes(MAXF);
    push_err();
    send_frame(MAXF + 1, -1);
    wait_idle(cyc);
    expect_int("oversize_tlast_idle_cycles", cyc, 13);
    expect_int("oversize_tlast_pulses", und_cnt, und0 + 1);
    expect_int("oversize_tlast_queue_empty", exp_q.size(), 0);
  endtask

  task automatic test_mid_reset();
    int cyc;
    push_preamble();
    push_bytes(9);
    for (int i = 0; i < 10; i++) drive_byte(8'(i), 1'b0);
    s_axis.tvalid = 1'b0;
    rst = 1'b1;
    #1;
    expect_int("midrst_tx_en", int'(gmii_tx_en), 0);
    expect_int("midrst_busy", int'(busy), 0);
    expect_int("midrst_tready", int'(s_axis.tready), 0);
    expect_int("midrst_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_preamble();
    push_bytes(64);
    send_frame(64, -1);
    wait_idle(cyc);
    expect_int("midrst_next_tx_en_len", last_hi, 72);
    expect_int("midrst_next_queue_empty", exp_q.size(), 0);
  endtask

`ifdef TX_FRAMER_STATS_EN
  task automatic test_stats();
    int cyc;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      push_preamble();
      push_bytes(64);
      send_frame(64, -1);
      wait_idle(cyc);
    end
    push_preamble();
    push_bytes(11);
    push_err();
    send_frame(64, 10);
    wait_idle(cyc);
    expect_int("stats_frames_sent", int'(frames_sent), 3);
    expect_int("stats_frames_aborted", int'(frames_aborted), 1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_oversize();
    test_oversize_tlast();
    test_mid_reset();
`ifdef TX_FRAMER_STATS_EN
    test_stats();
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
